dac80004_sequencer: RTL

- Upstream feeder for the DAC80004 SPI master.
- Holds one 16-bit setpoint per DAC channel with a dirty bit per channel.
- Formats the 32-bit DAC80004 write-and-update frames and issues them one at a time over the master's tx_valid/rx_valid handshake.
- Optional one-shot init frame after reset; inter-frame gap; timeout with sticky error.

---
 rtl/dac80004_pkg.sv | 36 +++
 rtl/dac80004_sequencer_rr_pick.sv | 36 +++
 rtl/dac80004_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dac80004_pkg.sv
// Shared constants, frame layout and FSM state encoding for the DAC80004 sequencer.
package dac80004_pkg;

   localparam logic [3:0] CMD_WR_UPD = 4'b0011;
   localparam logic [3:0] CMD_INTREF = 4'b1000;
   localparam logic [3:0] INTREF_ON  = 4'b0001;

   typedef struct packed {
      logic [3:0]  pad;
      logic [3:0]  cmd;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [3:0]  mode;
   } dac_frame_t;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      ISSUE,
      GAP
   } seq_state_t;

   function automatic dac_frame_t make_frame(input logic [3:0]  cmd,
                                             input logic [3:0]  addr,
                                             input logic [15:0] data,
                                             input logic [3:0]  mode);
      dac_frame_t f;
      f.pad  = 4'h0;
      f.cmd  = cmd;
      f.addr = addr;
      f.data = data;
      f.mode = mode;
      return f;
   endfunction

endpackage

// File: rtl/dac80004_sequencer_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr, wrapping modulo NCH.
module rr_pick #(
   parameter int NCH = 4
) (
   input  logic [NCH-1:0] i_req,
   input  logic [1:0]     i_ptr,
   output logic [1:0]     o_grant,
   output logic           o_any
);

   logic [2:0] w_sum;
   logic [1:0] w_idx;
   logic       w_found;

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      w_sum   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      o_grant = '0;
      for (int i = 0; i < NCH; i++) begin
         w_sum = {1'b0, i_ptr} + 3'(i);
         if (w_sum >= 3'(NCH)) begin
            w_sum = w_sum - 3'(NCH);
         end
         w_idx = w_sum[1:0];
         if (!w_found && i_req[w_idx]) begin
            o_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/dac80004_sequencer.sv
// Setpoint store with per-channel dirty bits; issues DAC80004 write-and-update frames
// to the SPI master one at a time, with optional init frame, inter-frame gap and timeout.
module dac80004_sequencer
   import dac80004_pkg::*;
#(
   parameter int NCH          = 4,
   parameter int GAP_CLKS     = 8,
   parameter int TIMEOUT_CLKS = 4096,
   parameter int INIT_INTREF  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [1:0]  wr_ch,
   input  logic [15:0] wr_data,
   input  logic        load_all,
   input  logic        err_clear,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [31:0] rx_data,
   output logic [31:0] last_rx,
   output logic        busy,
   output logic        err_timeout,
   output logic [15:0] frame_count
);

   localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
   localparam int GAP_W = $clog2(GAP_CLKS + 1);

   seq_state_t       r_state, w_state_nxt;
   logic             r_tx_valid, w_tx_valid_nxt;
   dac_frame_t       r_tx_data, w_tx_data_nxt;
   logic [31:0]      r_last_rx, w_last_rx_nxt;
   logic [15:0]      r_frame_cnt, w_frame_cnt_nxt;
   logic [TMO_W-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
   logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;
   logic [1:0]       r_ptr, w_ptr_nxt;
   logic [1:0]       r_inflight_ch, w_inflight_ch_nxt;
   logic             r_inflight_init, w_inflight_init_nxt;
   logic [NCH-1:0]   r_dirty, w_dirty_nxt;
   logic             r_err, w_err_nxt;
   logic             r_busy, w_busy_nxt;
   logic [15:0]      r_setpoint [NCH];

   logic [NCH-1:0]   w_pick_clr, w_retry_set, w_wr_set;
   logic             w_timeout;
   logic [1:0]       w_grant;
   logic             w_any;

   // tx_ready is informational only; sequencing relies on the rx_valid handshake.
   logic w_unused;
   assign w_unused = tx_ready;

   rr_pick #(.NCH(NCH)) u_rr_pick (
      .i_req   (r_dirty),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_any   (w_any)
   );

   always_comb begin
      w_state_nxt         = r_state;
      w_tx_valid_nxt      = r_tx_valid;
      w_tx_data_nxt       = r_tx_data;
      w_last_rx_nxt       = r_last_rx;
      w_frame_cnt_nxt     = r_frame_cnt;
      w_tmo_cnt_nxt       = r_tmo_cnt;
      w_gap_cnt_nxt       = r_gap_cnt;
      w_ptr_nxt           = r_ptr;
      w_inflight_ch_nxt   = r_inflight_ch;
      w_inflight_init_nxt = r_inflight_init;
      w_pick_clr          = '0;
      w_retry_set         = '0;
      w_timeout           = 1'b0;

      case (r_state)
         INIT: begin
            if (INIT_INTREF != 0) begin
               w_tx_data_nxt       = make_frame(CMD_INTREF, 4'h0, 16'h0000, INTREF_ON);
               w_tx_valid_nxt      = 1'b1;
               w_inflight_init_nxt = 1'b1;
               w_tmo_cnt_nxt       = '0;
               w_state_nxt         = ISSUE;
            end else begin
               w_state_nxt = IDLE;
            end
         end

         IDLE: begin
            if (w_any) begin
               w_tx_data_nxt       = make_frame(CMD_WR_UPD, {2'b00, w_grant},
                                                r_setpoint[w_grant], 4'h0);
               w_pick_clr[w_grant] = 1'b1;
               w_ptr_nxt           = (w_grant == 2'(NCH - 1)) ? 2'd0 : w_grant + 2'd1;
               w_inflight_ch_nxt   = w_grant;
               w_inflight_init_nxt = 1'b0;
               w_tx_valid_nxt      = 1'b1;
               w_tmo_cnt_nxt       = '0;
               w_state_nxt         = ISSUE;
            end
         end

         ISSUE: begin
            if (rx_valid) begin
               w_last_rx_nxt   = rx_data;
               w_frame_cnt_nxt = r_frame_cnt + 16'd1;
               w_tx_valid_nxt  = 1'b0;
               w_gap_cnt_nxt   = '0;
               w_state_nxt     = GAP;
            end else if (r_tmo_cnt == TMO_W'(TIMEOUT_CLKS - 1)) begin
               // An abandoned setpoint frame is retried; the init frame is not.
               w_timeout      = 1'b1;
               w_tx_valid_nxt = 1'b0;
               w_gap_cnt_nxt  = '0;
               w_state_nxt    = GAP;
               if (!r_inflight_init) begin
                  w_retry_set[r_inflight_ch] = 1'b1;
               end
            end else begin
               w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
            end
         end

         GAP: begin
            if (r_gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
               w_state_nxt = IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + GAP_W'(1);
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_wr_set = '0;
      for (int i = 0; i < NCH; i++) begin
         if (wr_en && (wr_ch == 2'(i))) begin
            w_wr_set[i] = 1'b1;
         end
      end
   end

   // Clear is applied first so a coincident write, retry or load_all keeps the bit set.
   assign w_dirty_nxt = (r_dirty & ~w_pick_clr) | w_retry_set | w_wr_set
                      | (load_all ? {NCH{1'b1}} : {NCH{1'b0}});
   assign w_err_nxt   = (r_err & ~err_clear) | w_timeout;
   assign w_busy_nxt  = (w_state_nxt != IDLE) || (|w_dirty_nxt);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state         <= INIT;
         r_tx_valid      <= 1'b0;
         r_tx_data       <= '0;
         r_last_rx       <= '0;
         r_frame_cnt     <= '0;
         r_tmo_cnt       <= '0;
         r_gap_cnt       <= '0;
         r_ptr           <= '0;
         r_inflight_ch   <= '0;
         r_inflight_init <= 1'b0;
         r_dirty         <= '0;
         r_err           <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_tx_valid      <= w_tx_valid_nxt;
         r_tx_data       <= w_tx_data_nxt;
         r_last_rx       <= w_last_rx_nxt;
         r_frame_cnt     <= w_frame_cnt_nxt;
         r_tmo_cnt       <= w_tmo_cnt_nxt;
         r_gap_cnt       <= w_gap_cnt_nxt;
         r_ptr           <= w_ptr_nxt;
         r_inflight_ch   <= w_inflight_ch_nxt;
         r_inflight_init <= w_inflight_init_nxt;
         r_dirty         <= w_dirty_nxt;
         r_err           <= w_err_nxt;
         r_busy          <= w_busy_nxt;
      end
   end

   // NOTE: the setpoint store is reset because its contents are visible in frames after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_setpoint[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (w_wr_set[i]) begin
               r_setpoint[i] <= wr_data;
            end
         end
      end
   end

   assign tx_valid    = r_tx_valid;
   assign tx_data     = r_tx_data;
   assign last_rx     = r_last_rx;
   assign busy        = r_busy;
   assign err_timeout = r_err;
   assign frame_count = r_frame_cnt;

endmodule
